// File: rtl/fps_counter.sv
// AXI4-Lite frame-rate monitor that passively snoops an AXI-Stream video bus.
// Counts frame starts per window, a running frame total and lines of the last frame.
module fps_counter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int AXIS_DATA_WIDTH  = 8,
    parameter int INVERT_AXI_RESET = 0,
    parameter int CLOCK_FREQUENCY  = 100000000
) (
    input  logic                       i_axi_clk,
    input  logic                       i_axi_rst,
    input  logic                       i_awvalid,
    input  logic [ADDR_WIDTH-1:0]      i_awaddr,
    output logic                       o_awready,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic [31:0]                i_wdata,
    input  logic [3:0]                 i_wstrb,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    output logic [1:0]                 o_bresp,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    input  logic [ADDR_WIDTH-1:0]      i_araddr,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [1:0]                 o_rresp,
    output logic [31:0]                o_rdata,
    input  logic                       i_axis_in_tuser,
    input  logic                       i_axis_in_tvalid,
    input  logic                       i_axis_in_tready,
    input  logic                       i_axis_in_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0] i_axis_in_tdata
);

    localparam int          IW      = ADDR_WIDTH - 2;
    localparam logic [31:0] VERSION = 32'h0001_0000;

    logic        rst;
    logic        en;
    logic [31:0] window;
    logic [31:0] win_cnt;
    logic [31:0] win_frames;
    logic [31:0] fps;
    logic [31:0] frame_total;
    logic [31:0] line_cnt;
    logic [31:0] lines;

    logic          wr_fire;
    logic          rd_fire;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_val;
    logic          clear;
    logic          sof;
    logic          eol;
    logic [31:0]   win_last;
    logic          win_done;
    logic          unused_bits;

    assign rst = (INVERT_AXI_RESET != 0) ? ~i_axi_rst : i_axi_rst;

    assign wr_fire = o_awready & i_awvalid & i_wvalid;
    assign rd_fire = o_arready & i_arvalid;
    assign wr_idx  = i_awaddr[ADDR_WIDTH-1:2];
    assign rd_idx  = i_araddr[ADDR_WIDTH-1:2];

    assign clear = wr_fire & (wr_idx == IW'(0)) & i_wstrb[0] & i_wdata[1];
    assign sof   = i_axis_in_tvalid & i_axis_in_tready & i_axis_in_tuser;
    assign eol   = i_axis_in_tvalid & i_axis_in_tready & i_axis_in_tlast;

    // A window length of 0 is treated as 1 cycle.
    assign win_last = (window == 32'd0) ? 32'd0 : window - 32'd1;
    assign win_done = (win_cnt >= win_last);

    assign o_bresp = 2'b00;
    assign o_rresp = 2'b00;

    assign unused_bits = ^{i_axis_in_tdata, i_awaddr[1:0], i_araddr[1:0]};

    function automatic logic [31:0] apply_strb(
        input logic [31:0] cur,
        input logic [31:0] wdat,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = wdat[8*b +: 8];
        end
        return r;
    endfunction

    // Write channel: one-cycle ready pulse, then hold the response until accepted.
    always_ff @(posedge i_axi_clk or posedge rst) begin
        if (rst) begin
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            o_bvalid  <= 1'b0;
        end else begin
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            if (i_awvalid && i_wvalid && !o_bvalid && !o_awready) begin
                o_awready <= 1'b1;
                o_wready  <= 1'b1;
            end
            if (wr_fire) begin
                o_bvalid <= 1'b1;
            end else if (i_bready) begin
                o_bvalid <= 1'b0;
            end
        end
    end

    // Writable registers, updated byte-wise on the write handshake edge.
    always_ff @(posedge i_axi_clk or posedge rst) begin
        if (rst) begin
            en     <= 1'b0;
            window <= 32'(CLOCK_FREQUENCY);
        end else if (wr_fire) begin
            case (wr_idx)
                IW'(0): if (i_wstrb[0]) en <= i_wdata[0];
                IW'(1): window <= apply_strb(window, i_wdata, i_wstrb);
                default: ;
            endcase
        end
    end

    // Read data mux; unmapped addresses read as zero.
    always_comb begin
        rd_val = 32'd0;
        case (rd_idx)
            IW'(0): rd_val = {31'd0, en};
            IW'(1): rd_val = window;
            IW'(2): rd_val = fps;
            IW'(3): rd_val = frame_total;
            IW'(4): rd_val = lines;
            IW'(5): rd_val = VERSION;
            default: rd_val = 32'd0;
        endcase
    end

    // Read channel: registered data held stable until the master takes it.
    always_ff @(posedge i_axi_clk or posedge rst) begin
        if (rst) begin
            o_arready <= 1'b0;
            o_rvalid  <= 1'b0;
            o_rdata   <= 32'd0;
        end else begin
            o_arready <= 1'b0;
            if (i_arvalid && !o_rvalid && !o_arready) o_arready <= 1'b1;
            if (rd_fire) begin
                o_rvalid <= 1'b1;
                o_rdata  <= rd_val;
            end else if (i_rready) begin
                o_rvalid <= 1'b0;
            end
        end
    end

    // Window, frame and line counting; CLEAR has priority over stream events.
    always_ff @(posedge i_axi_clk or posedge rst) begin
        if (rst) begin
            win_cnt     <= 32'd0;
            win_frames  <= 32'd0;
            fps         <= 32'd0;
            frame_total <= 32'd0;
            line_cnt    <= 32'd0;
            lines       <= 32'd0;
        end else if (clear) begin
            win_cnt     <= 32'd0;
            win_frames  <= 32'd0;
            fps         <= 32'd0;
            frame_total <= 32'd0;
            line_cnt    <= 32'd0;
            lines       <= 32'd0;
        end else if (en) begin
            if (win_done) begin
                fps        <= win_frames + {31'd0, sof};
                win_cnt    <= 32'd0;
                win_frames <= 32'd0;
            end else begin
                win_cnt    <= win_cnt + 32'd1;
                win_frames <= win_frames + {31'd0, sof};
            end
            if (sof) begin
                frame_total <= frame_total + 32'd1;
                lines       <= line_cnt;
                line_cnt    <= {31'd0, eol};
            end else if (eol) begin
                line_cnt <= line_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fps_counter.sv
// Self-checking bench for fps_counter: directed AXI-Lite steps plus a
// randomized stream checked against a frame-counting reference model.
module tb_fps_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        tuser = 1'b0, tvalid = 1'b0, tready = 1'b0, tlast = 1'b0;
    logic [7:0]  tdata = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    fps_counter dut (
        .i_axi_clk(clk), .i_axi_rst(rst),
        .i_awvalid(awvalid), .i_awaddr(awaddr), .o_awready(awready),
        .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
        .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
        .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
        .o_rvalid(rvalid), .i_rready(rready), .o_rresp(rresp), .o_rdata(rdata),
        .i_axis_in_tuser(tuser), .i_axis_in_tvalid(tvalid),
        .i_axis_in_tready(tready), .i_axis_in_tlast(tlast),
        .i_axis_in_tdata(tdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: evaluated mid-cycle for the effect of the next rising edge.
    logic        m_en;
    logic [31:0] m_win, m_elapsed, m_wframes, m_fps, m_total, m_line, m_lines, m_rexp;

    function automatic logic [31:0] model_reg(input int idx);
        case (idx)
            0: return {31'd0, m_en};
            1: return m_win;
            2: return m_fps;
            3: return m_total;
            4: return m_lines;
            5: return 32'h0001_0000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic sof, eol, wr, clr;
        int   widx;
        if (rst) begin
            m_en = 0; m_win = 32'd100000000; m_elapsed = 0; m_wframes = 0;
            m_fps = 0; m_total = 0; m_line = 0; m_lines = 0;
            return;
        end
        if (arready && arvalid) m_rexp = model_reg(int'(araddr[31:2]));
        sof  = tvalid && tready && tuser;
        eol  = tvalid && tready && tlast;
        wr   = awready && awvalid && wvalid;
        widx = int'(awaddr[31:2]);
        clr  = wr && widx == 0 && wstrb[0] && wdata[1];
        if (clr) begin
            m_elapsed = 0; m_wframes = 0; m_fps = 0;
            m_total = 0; m_line = 0; m_lines = 0;
        end else if (m_en) begin
            m_wframes += 32'(sof);
            // The window closes on its W-th enabled cycle (W=0 acts as 1).
            if (m_elapsed + 1 >= ((m_win == 0) ? 1 : m_win)) begin
                m_fps = m_wframes;
                m_elapsed = 0;
                m_wframes = 0;
            end else begin
                m_elapsed++;
            end
            if (sof) begin
                m_total++;
                m_lines = m_line;
                m_line = 32'(eol);
            end else if (eol) begin
                m_line++;
            end
        end
        if (wr && widx == 0 && wstrb[0]) m_en = wdata[0];
        if (wr && widx == 1)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) m_win[8*b +: 8] = wdata[8*b +: 8];
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1; bready = 1;
        while (!awready && k < 20) begin tick(); k++; end
        check("aw_timeout", 32'(k >= 20), 32'd0);
        tick();
        awvalid = 0; wvalid = 0;
        k = 0;
        while (!bvalid && k < 20) begin tick(); k++; end
        check("bresp", {30'd0, bresp}, 32'd0);
        tick();
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int k = 0;
        araddr = a; arvalid = 1; rready = 1;
        while (!arready && k < 20) begin tick(); k++; end
        check("ar_timeout", 32'(k >= 20), 32'd0);
        tick();
        arvalid = 0;
        k = 0;
        while (!rvalid && k < 20) begin tick(); k++; end
        d = rdata;
        check("rresp", {30'd0, rresp}, 32'd0);
        tick();
        rready = 0;
    endtask

    task automatic read_model(input logic [31:0] a, input string tag);
        logic [31:0] d;
        axi_read(a, d);
        check(tag, d, m_rexp);
    endtask

    task automatic read_const(input logic [31:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check(tag, d, m_rexp);
        check({tag, "_c"}, d, exp);
    endtask

    // mode 0: SOF every 20; 1: 4-line frames; 2: beats never complete; 3: random
    task automatic stream(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            case (mode)
                0: begin tvalid = 1; tready = 1; tuser = (k % 20 == 0); tlast = 0; end
                1: begin tvalid = 1; tready = 1; tuser = (k % 12 == 0); tlast = (k % 3 == 2); end
                2: begin
                    tuser = 1; tlast = 1;
                    tvalid = $urandom_range(0, 1) == 1;
                    tready = ~tvalid;
                end
                default: begin
                    tvalid = $urandom_range(0, 3) != 0;
                    tready = $urandom_range(0, 3) != 0;
                    tuser  = $urandom_range(0, 14) == 0;
                    tlast  = $urandom_range(0, 3) == 0;
                end
            endcase
            tdata = 8'($urandom);
            tick();
        end
        tvalid = 0; tready = 0; tuser = 0; tlast = 0;
    endtask

    logic [31:0] d;

    initial begin
        repeat (3) tick();
        check("rst_outs", {23'd0, awready, wready, bvalid, arready, rvalid, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 0;
        tick();

        read_const(32'h0, "ctrl0", 32'd0);
        read_const(32'h4, "window0", 32'd100000000);
        read_const(32'h8, "fps0", 32'd0);
        read_const(32'hC, "total0", 32'd0);
        read_const(32'h14, "version", 32'h0001_0000);
        read_const(32'h40, "unmapped", 32'd0);

        axi_write(32'h4, 32'd100, 4'hF);
        axi_write(32'h0, 32'd1, 4'hF);
        fork
            stream(300, 0);
            begin
                repeat (250) tick();
                read_const(32'h8, "fps5", 32'd5);
            end
        join
        read_const(32'hC, "total15", 32'd15);

        stream(30, 1);
        read_const(32'h10, "lines4", 32'd4);
        read_const(32'hC, "total18", 32'd18);

        stream(50, 2);
        read_const(32'hC, "noevent_total", 32'd18);
        read_const(32'h10, "noevent_lines", 32'd4);

        axi_write(32'h0, 32'd3, 4'hF);
        read_const(32'h8, "clr_fps", 32'd0);
        read_const(32'hC, "clr_total", 32'd0);
        read_const(32'h10, "clr_lines", 32'd0);
        read_const(32'h0, "clr_ctrl", 32'd1);
        stream(60, 0);
        read_const(32'hC, "resume_total", 32'd3);

        axi_write(32'h4, 32'hFFFF_FF00, 4'h1);
        read_const(32'h4, "strb_window", 32'd0);
        axi_write(32'h0, 32'd2, 4'h2);
        read_const(32'h0, "strb_noclr", 32'd1);

        axi_write(32'h4, 32'($urandom_range(10, 60)), 4'hF);
        fork
            stream(1500, 3);
            begin
                for (int i = 0; i < 30; i++) begin
                    int op = $urandom_range(0, 9);
                    if (op == 0)
                        axi_write(32'h4, 32'($urandom_range(0, 40)), 4'($urandom_range(1, 15)));
                    else if (op == 1)
                        axi_write(32'h0, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 1)));
                    else if (op == 2)
                        axi_write(32'h0, 32'd1, 4'h1);
                    else
                        read_model(32'(4 * $urandom_range(0, 6)), "rand_rd");
                    repeat ($urandom_range(5, 40)) tick();
                end
            end
        join
        read_model(32'h8, "rand_fps");
        read_model(32'hC, "rand_total");
        read_model(32'h10, "rand_lines");

        araddr = 32'h4; arvalid = 1; rready = 0;
        for (int k = 0; k < 20 && !arready; k++) tick();
        tick();
        d = rdata;
        check("bp_rdata_first", d, m_rexp);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_rvalid", {31'd0, rvalid}, 32'd1);
            check("bp_rdata", rdata, m_rexp);
            check("bp_arready", {31'd0, arready}, 32'd0);
        end
        arvalid = 0; rready = 1;
        tick();
        rready = 0;
        check("bp_rvalid_drop", {31'd0, rvalid}, 32'd0);

        awaddr = 32'h4; wdata = 32'd55; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; bready = 0;
        for (int k = 0; k < 20 && !awready; k++) tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_bvalid", {31'd0, bvalid}, 32'd1);
            check("bp_awready", {31'd0, awready}, 32'd0);
        end
        awvalid = 0; wvalid = 0; bready = 1;
        tick();
        bready = 0;
        check("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
        read_const(32'h4, "bp_window", 32'd55);

        araddr = 32'h4; arvalid = 1; rready = 0;
        for (int k = 0; k < 20 && !arready; k++) tick();
        tick();
        #2 rst = 1;
        #1;
        check("midrst_outs", {23'd0, awready, wready, bvalid, arready, rvalid, bresp, rresp}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        arvalid = 0;
        tick();
        tick();
        rst = 0;
        tick();
        read_const(32'h4, "post_rst_window", 32'd100000000);
        read_const(32'h0, "post_rst_ctrl", 32'd0);
        read_const(32'hC, "post_rst_total", 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fps_counter.md
Name: fps_counter

Overview:
- AXI4-Lite-controlled frame-rate monitor.
- Passively snoops an AXI-Stream video bus (tuser = start of frame, tlast = end of line) and counts frames per measurement window.
- Also keeps a running frame total and the line count of the last frame.
- Sits beside a video pipeline as a debug/status peripheral; never drives the stream.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width.
AXIS_DATA_WIDTH, 8, stream tdata width (data ignored).
INVERT_AXI_RESET, 0, 0: i_axi_rst active-high; 1: i_axi_rst is inverted internally (active-low).
CLOCK_FREQUENCY, 100000000, reset value of the WINDOW register (cycles per measurement window).

Ports:
i_axi_clk  in  1  single clock for all logic
i_axi_rst  in  1  asynchronous, active-high reset (with INVERT_AXI_RESET=0)
i_awvalid  in  1  write address valid
i_awaddr  in  ADDR_WIDTH  write byte address
o_awready  out  1  write address ready
i_wvalid  in  1  write data valid
o_wready  out  1  write data ready
i_wdata  in  32  write data
i_wstrb  in  4  byte strobes
o_bvalid  out  1  write response valid
i_bready  in  1  write response ready
o_bresp  out  2  write response, always 2'b00 OKAY
i_arvalid  in  1  read address valid
o_arready  out  1  read address ready
i_araddr  in  ADDR_WIDTH  read byte address
o_rvalid  out  1  read data valid
i_rready  in  1  read data ready
o_rresp  out  2  read response, always 2'b00
o_rdata  out  32  read data
i_axis_in_tuser  in  1  start-of-frame marker
i_axis_in_tvalid  in  1  stream valid
i_axis_in_tready  in  1  stream ready, monitored only
i_axis_in_tlast  in  1  end-of-line marker
i_axis_in_tdata  in  AXIS_DATA_WIDTH  ignored

Behaviour:

Reset (async, immediate):
- All outputs 0; CONTROL=0; WINDOW=CLOCK_FREQUENCY; all counters 0.

Register map (word index = addr[ADDR_WIDTH-1:2]; low 2 bits ignored):
- 0 CONTROL RW: bit0 EN; bit1 CLEAR (write-1 pulse, self-clears, reads 0); other bits read 0.
- 1 WINDOW RW: 32-bit window length in cycles. Value 0 behaves as 1.
- 2 FPS RO: frame starts counted in the last completed window.
- 3 FRAME_TOTAL RO: frame starts since reset/CLEAR, 32-bit wrap.
- 4 LINES RO: tlast beats in the last completed frame.
- 5 VERSION RO: 0x00010000.
- Other addresses: reads return 0; writes are ignored. Response is OKAY in both cases.

Byte strobes:
- Honoured on RW registers per byte.
- CLEAR takes effect only if wstrb[0]=1.

Write path:
- o_awready and o_wready assert together for one cycle when i_awvalid & i_wvalid & !o_bvalid.
- Register updates on that edge.
- o_bvalid rises the next cycle and holds until i_bready.

Read path:
- o_arready asserts for one cycle when i_arvalid & !o_rvalid.
- o_rdata is registered; o_rvalid rises the next cycle and holds (data stable) until i_rready.
- Reads and writes are independent; both may complete in the same cycle.

Stream events (beat = tvalid & tready):
- SOF = beat & tuser.
- EOL = beat & tlast.

Counting:
- Window cycle counter runs only while EN=1.
- When the counter reaches WINDOW-1:
  - FPS <= window frame count, including an SOF on that same cycle.
  - Window counter and window frame count reset to 0.
- FRAME_TOTAL increments on each SOF while EN=1.
- Line counter increments on EOL while EN=1.
- On SOF: LINES <= current line counter; line counter restarts at (EOL on this beat ? 1 : 0).
- EN=0 freezes all counters; FPS, FRAME_TOTAL and LINES hold.
- CLEAR zeroes window counter, window frame count, FPS, FRAME_TOTAL, line counter and LINES. CLEAR wins over a simultaneous SOF/EOL.
- WINDOW written mid-window: new length applies immediately. If the counter is already ≥ new WINDOW-1, the window completes on the next cycle.
- Counters saturate nowhere; they wrap at 2^32.

Test Plan:
- Reset, then read addresses 0,1,2,3,5 -> 0, 100000000, 0, 0, 0x00010000; bresp and rresp always 0.
- Write WINDOW=100, EN=1; drive one SOF every 20 cycles for 300 cycles -> FPS=5 after each window; FRAME_TOTAL=15.
- Frames of 4 lines (tlast every 3rd beat, tuser at line 0) -> LINES=4 after the second SOF.
- SOF beats with tready=0 or tvalid=0 -> no counts change.
- Write CONTROL=0x3 mid-run -> FPS, FRAME_TOTAL, LINES read 0; counting resumes; CONTROL reads 0x1.
- Hold i_bready/i_rready low 5 cycles -> bvalid/rvalid and rdata stay stable, no new handshake.
- Assert reset mid-transaction -> all outputs 0 immediately.
